// File: rtl/cache_perf_mon.sv
`default_nettype none
// ============================================================================
// Module      : cache_perf_mon
// Description : Cache performance monitor. NUM_CH event counters plus one
//               cycle counter, gated by a small IDLE/RUN/FROZEN controller,
//               with sticky overflow flags and a registered readout mux.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_perf_mon #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 0,
    parameter int SEL_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [NUM_CH-1:0] evt,
    input  logic              halt,
    input  logic              clr,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic              frozen,
    output logic              running
);

    // Counter slot NUM_CH holds the cycle counter; slots below are channels.
    localparam int               c_NUM_CNT  = NUM_CH + 1;
    localparam logic [CNT_W-1:0] c_ALL_ONES = '1;
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } stateT;

    stateT                             r_state;
    stateT                             w_nextState;
    logic [c_NUM_CNT-1:0][CNT_W-1:0]   r_cnt;
    logic [NUM_CH:0]                   r_ovf;
    logic [NUM_CH:0]                   w_inc;
    logic [CNT_W-1:0]                  r_rdData;
    logic [CNT_W-1:0]                  w_rdMux;
    logic                              w_count;

    // Counting happens only in RUN with en high; a clear in the same cycle wins.
    assign w_count = (r_state == S_RUN) && en && !clr;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_inc
            assign w_inc[gi] = w_count & evt[gi];
        end
    endgenerate
    assign w_inc[NUM_CH] = w_count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: clr beats halt beats start; FROZEN only leaves via clr/rst.
    always_comb begin
        w_nextState = r_state;
        if (clr) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_nextState = S_RUN;
                S_RUN:    if (halt)  w_nextState = S_FROZEN;
                S_FROZEN: w_nextState = S_FROZEN;
                default:  w_nextState = S_IDLE;
            endcase
        end
    end

    // Counters and sticky overflow flags; at all-ones either wrap or saturate.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < c_NUM_CNT; i++) begin
                if (w_inc[i]) begin
                    if (r_cnt[i] == c_ALL_ONES) begin
                        r_ovf[i] <= 1'b1;
                        if (SAT_MODE == 0) begin
                            r_cnt[i] <= '0;
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + c_ONE;
                    end
                end
            end
        end
    end

    // Readout select; out-of-range selects return zero.
    always_comb begin
        w_rdMux = '0;
        for (int i = 0; i < c_NUM_CNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                w_rdMux = r_cnt[i];
            end
        end
    end

    // Readout register samples pre-increment (and pre-clear) counter values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= w_rdMux;
        end
    end

    assign rd_data = r_rdData;
    assign ovf     = r_ovf;
    assign frozen  = (r_state == S_FROZEN);
    assign running = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_cache_perf_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_perf_mon
// Description : Self-checking bench for cache_perf_mon. Runs a wrap-mode and
//               a saturate-mode instance side by side against a behavioural
//               model, with directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_perf_mon;

    logic       clk;
    logic       rst;
    logic       start;
    logic       en;
    logic [3:0] evt;
    logic       halt;
    logic       clr;
    logic [2:0] rdSel;

    logic [7:0] rdWrap, rdSat;
    logic [4:0] ovfWrap, ovfSat;
    logic       frozenWrap, frozenSat, runningWrap, runningSat;

    int nChecks = 0;
    int nFail   = 0;

    // Model: state 0 idle, 1 run, 2 frozen; index [0] wrap instance, [1] saturate.
    int       mState;
    int       mCnt [2][5];
    bit [4:0] mOvf [2];
    int       mRd  [2];

    cache_perf_mon #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0), .SEL_W(3)) dutWrap (
        .clk(clk), .rst(rst), .start(start), .en(en), .evt(evt), .halt(halt),
        .clr(clr), .rd_sel(rdSel), .rd_data(rdWrap), .ovf(ovfWrap),
        .frozen(frozenWrap), .running(runningWrap)
    );

    cache_perf_mon #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1), .SEL_W(3)) dutSat (
        .clk(clk), .rst(rst), .start(start), .en(en), .evt(evt), .halt(halt),
        .clr(clr), .rd_sel(rdSel), .rd_data(rdSat), .ovf(ovfSat),
        .frozen(frozenSat), .running(runningSat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    function automatic void modelStep();
        if (rst) begin
            mState = 0;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 5; i++) mCnt[m][i] = 0;
                mOvf[m] = '0;
                mRd[m]  = 0;
            end
            return;
        end
        for (int m = 0; m < 2; m++) begin
            mRd[m] = (int'(rdSel) < 5) ? mCnt[m][rdSel] : 0;
        end
        if (clr) begin
            mState = 0;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 5; i++) mCnt[m][i] = 0;
                mOvf[m] = '0;
            end
            return;
        end
        if (mState == 1 && en) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 5; i++) begin
                    if (i == 4 || evt[i]) begin
                        int v;
                        v = mCnt[m][i] + 1;
                        if (v > 255) begin
                            mOvf[m][i] = 1'b1;
                            v = (m == 1) ? 255 : v - 256;
                        end
                        mCnt[m][i] = v;
                    end
                end
            end
        end
        if (mState == 0 && start) mState = 1;
        else if (mState == 1 && halt) mState = 2;
    endfunction

    // One clock: update model, wait past the edge, compare all outputs.
    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkVal("rdWrap",     32'(rdWrap),      32'(mRd[0]));
        checkVal("rdSat",      32'(rdSat),       32'(mRd[1]));
        checkVal("ovfWrap",    32'(ovfWrap),     32'(mOvf[0]));
        checkVal("ovfSat",     32'(ovfSat),      32'(mOvf[1]));
        checkVal("runWrap",    32'(runningWrap), 32'(mState == 1));
        checkVal("runSat",     32'(runningSat),  32'(mState == 1));
        checkVal("frozenWrap", 32'(frozenWrap),  32'(mState == 2));
        checkVal("frozenSat",  32'(frozenSat),   32'(mState == 2));
    endtask

    task automatic readSel(input int sel, output int vWrap, output int vSat);
        rdSel = 3'(sel);
        tick();
        vWrap = int'(rdWrap);
        vSat  = int'(rdSat);
    endtask

    initial begin
        int vW, vS;
        int expFrozen [8] = '{11, 1, 11, 1, 11, 0, 0, 0};

        rst = 1'b1; start = 1'b0; en = 1'b0; evt = '0;
        halt = 1'b0; clr = 1'b0; rdSel = '0;
        tick();
        tick();
        checkVal("rstRd",      32'(rdWrap),      0);
        checkVal("rstOvf",     32'(ovfWrap),     0);
        checkVal("rstRunning", 32'(runningWrap), 0);
        checkVal("rstFrozen",  32'(frozenWrap),  0);
        rst = 1'b0;

        // Count 10 cycles of evt=0101, then halt with all events set.
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; evt = 4'b0101;
        repeat (10) tick();
        halt = 1'b1; evt = 4'b1111; tick();
        halt = 1'b0;
        checkVal("haltFrozen", 32'(frozenWrap), 1);
        repeat (5) begin
            evt = 4'($urandom); start = 1'($urandom); halt = 1'($urandom);
            tick();
        end
        evt = '0; start = 1'b0; halt = 1'b0;
        for (int s = 0; s < 8; s++) begin
            readSel(s, vW, vS);
            checkVal($sformatf("frozenSelW%0d", s), 32'(vW), 32'(expFrozen[s]));
            checkVal($sformatf("frozenSelS%0d", s), 32'(vS), 32'(expFrozen[s]));
        end

        // 257 cycles of evt[0]: wrap yields 1, saturate holds 255.
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; evt = 4'b0001;
        repeat (257) tick();
        en = 1'b0; evt = '0;
        readSel(0, vW, vS);
        checkVal("wrapCh0",    32'(vW), 1);
        checkVal("satCh0",     32'(vS), 255);
        checkVal("wrapOvf0",   32'(ovfWrap[0]), 1);
        checkVal("wrapOvfCyc", 32'(ovfWrap[4]), 1);

        // 300 cycles of evt[2].
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; evt = 4'b0100;
        repeat (300) tick();
        en = 1'b0; evt = '0;
        readSel(2, vW, vS);
        checkVal("satCh2",   32'(vS), 255);
        checkVal("wrapCh2",  32'(vW), 44);
        checkVal("satOvf2",  32'(ovfSat[2]), 1);
        checkVal("satOvf0",  32'(ovfSat[0]), 0);

        // clr and halt together in RUN: clear wins, readout shows pre-clear value.
        rdSel = 3'd2; clr = 1'b1; halt = 1'b1; tick();
        clr = 1'b0; halt = 1'b0;
        checkVal("clrPreRd",   32'(rdSat), 255);
        checkVal("clrRunning", 32'(runningSat), 0);
        checkVal("clrFrozen",  32'(frozenSat), 0);
        checkVal("clrOvf",     32'(ovfSat), 0);
        for (int s = 0; s < 5; s++) begin
            readSel(s, vW, vS);
            checkVal($sformatf("clrSel%0d", s), 32'(vS), 0);
        end

        // rst mid-RUN discards counts; counting restarts from zero.
        start = 1'b1; tick(); start = 1'b0;
        en = 1'b1; evt = 4'b1111;
        repeat (5) tick();
        en = 1'b0; evt = '0;
        readSel(1, vW, vS);
        checkVal("preRstCh1", 32'(vW), 5);
        rst = 1'b1; tick(); rst = 1'b0;
        checkVal("rstRunRd",      32'(rdWrap), 0);
        checkVal("rstRunRunning", 32'(runningWrap), 0);
        start = 1'b1; tick(); start = 1'b0;
        checkVal("restartRunning", 32'(runningWrap), 1);
        en = 1'b1; evt = 4'b1111;
        repeat (3) tick();
        en = 1'b0; evt = '0;
        readSel(3, vW, vS);
        checkVal("restartCh3", 32'(vW), 3);
        readSel(4, vW, vS);
        checkVal("restartCyc", 32'(vW), 3);

        // Random traffic against the model.
        repeat (800) begin
            rst   = ($urandom_range(0, 59) == 0);
            clr   = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 7) == 0);
            halt  = ($urandom_range(0, 29) == 0);
            en    = ($urandom_range(0, 3) != 0);
            evt   = 4'($urandom);
            rdSel = 3'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
